// File: rtl/pcie_rx_demux_pkg.sv
// pcie_rx_pkg: shared constants, types and the BAR priority helper for pcie_rx_demux.
package pcie_rx_pkg;
  localparam int TUSER_BAR_LSB = 2;
  localparam int NUM_BARS = 7;
  typedef logic [NUM_BARS-1:0] bar_hit_t;
  typedef enum logic [1:0] {ST_SOF, ST_PKT, ST_DROP} state_t;
  function automatic logic [2:0] lowest_bar(bar_hit_t h);
    lowest_bar = 3'd7;
    for (int i = NUM_BARS - 1; i >= 0; i--) if (h[i]) lowest_bar = 3'(i);
  endfunction
endpackage

// File: rtl/pcie_rx_demux_axis_skid_buffer.sv
// axis_skid_buffer: 2-entry registered FIFO; in_ready comes from a flop, so it never depends on out_ready.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q, push, pop;
  always_comb begin
    push = in_valid & rdy_q;
    pop = out_ready & (cnt_q != 2'd0);
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    e0_d = pop ? e1_q : e0_q;
    e1_d = e1_q;
    if (push) begin
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) e0_d = in_data;
      else e1_d = in_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != 2'd2;
    end
  end
  assign in_ready = rdy_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_data = e0_q;
endmodule

// File: rtl/pcie_rx_demux.sv
// pcie_rx_demux: routes whole RX TLPs to per-BAR channels or drops them, with per-channel backpressure.
// Optional `PCIE_RX_DEMUX_STATS_EN builds the delivered/dropped packet counters.
module pcie_rx_demux
  import pcie_rx_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = C_DATA_WIDTH / 8,
  parameter int NUM_CH = 2,
  parameter int CHW = $clog2(NUM_CH + 1),
  parameter logic [7*CHW-1:0] BAR_ROUTE = '0,
  parameter int NOHIT_ROUTE = NUM_CH
) (
  input  logic                    user_clk,
  input  logic                    user_reset_n,
  output logic                    s_axis_rx_tready,
  input  logic                    s_axis_rx_tvalid,
  input  logic                    s_axis_rx_tlast,
  input  logic [KEEP_WIDTH-1:0]   s_axis_rx_tkeep,
  input  logic [C_DATA_WIDTH-1:0] s_axis_rx_tdata,
  input  logic [21:0]             s_axis_rx_tuser,
  output logic [NUM_CH-1:0]       m_axis_tvalid,
  input  logic [NUM_CH-1:0]       m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [21:0]             m_axis_tuser,
  output logic [NUM_CH*32-1:0]    pkt_cnt,
  output logic [31:0]             drop_cnt
);
  localparam int PW = 1 + KEEP_WIDTH + C_DATA_WIDTH + 22;
  localparam int SW = PW + CHW;
  state_t state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d, route, head_ch;
  logic [2:0] bar;
  logic acc, fwd, out_vld, out_pop;
  logic [SW-1:0] head;
  always_comb begin
    bar = lowest_bar(s_axis_rx_tuser[TUSER_BAR_LSB +: NUM_BARS]);
    route = bar == 3'd7 ? CHW'(NOHIT_ROUTE) : BAR_ROUTE[CHW*int'(bar) +: CHW];
    ch_d = state_q == ST_SOF ? route : state_q == ST_PKT ? ch_q : CHW'(NUM_CH);
    acc = s_axis_rx_tvalid & s_axis_rx_tready;
    fwd = acc & (ch_d < CHW'(NUM_CH));
    state_d = !acc ? state_q : s_axis_rx_tlast ? ST_SOF : state_q != ST_SOF ? state_q :
              fwd ? ST_PKT : ST_DROP;
    head_ch = head[SW-1 -: CHW];
    m_axis_tvalid = out_vld ? NUM_CH'(1) << head_ch : '0;
    out_pop = |(m_axis_tvalid & m_axis_tready);
  end
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q <= ST_SOF;
      ch_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
    end
  end
  axis_skid_buffer #(.W(SW)) u_skid (
    .clk       (user_clk),
    .rst_n     (user_reset_n),
    .in_valid  (fwd),
    .in_ready  (s_axis_rx_tready),
    .in_data   ({ch_d, s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata, s_axis_rx_tuser}),
    .out_valid (out_vld),
    .out_ready (out_pop),
    .out_data  (head)
  );
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser} = head[PW-1:0];
`ifdef PCIE_RX_DEMUX_STATS_EN
  logic [NUM_CH*32-1:0] pkt_q, pkt_d;
  logic [31:0] drop_q, drop_d;
  always_comb begin
    pkt_d = pkt_q;
    for (int i = 0; i < NUM_CH; i++)
      if (m_axis_tvalid[i] & m_axis_tready[i] & m_axis_tlast) pkt_d[i*32 +: 32] = pkt_q[i*32 +: 32] + 32'd1;
    drop_d = drop_q + 32'(acc & ~fwd & s_axis_rx_tlast);
  end
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      pkt_q <= '0;
      drop_q <= '0;
    end else begin
      pkt_q <= pkt_d;
      drop_q <= drop_d;
    end
  end
  assign pkt_cnt = pkt_q;
  assign drop_cnt = drop_q;
`else
  assign pkt_cnt = '0;
  assign drop_cnt = '0;
`endif
endmodule
